// File: rtl/mul_div_if.sv
// Operand/result bundle between the EX stage and the iterative multiply/divide unit.
// Also carries the unit's FSM state for observation.
interface mul_div_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             flush_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic [1:0]       state_dbg;

    modport master (
        output start_i, flush_i, op_i, data1_i, data2_i,
        input  stall_o, done_o, result_o, state_dbg
    );

    modport slave (
        input  start_i, flush_i, op_i, data1_i, data2_i,
        output stall_o, done_o, result_o, state_dbg
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit for the EX stage.
// One bit per cycle, WIDTH iterations; divide-by-zero finishes one cycle after start.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input logic      clk_i,
    input logic      rst_i,
    mul_div_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    // Handshake: a start is taken only in IDLE with no flush; stall_o holds the pipeline
    // from that cycle until the result cycle, where done_o pulses once and stall_o drops
    // so the instruction advances with result_o. result_o then holds until the next result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q;
    logic [1:0]         op_q;
    logic [2*WIDTH-1:0] prod_q, mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   rem_q, quo_q, divisor_q;
    logic [WIDTH-1:0]   result_q;

    logic               accept, div_zero, last_iter;
    logic               stall, done;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH:0]     rem_shift, rem_diff;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_nxt, quo_nxt;
    logic [WIDTH-1:0]   iter_result, dz_result;

    assign accept    = (state_q == IDLE) && bus.start_i && !bus.flush_i;
    assign div_zero  = bus.op_i[1] && (bus.data2_i == '0);
    assign last_iter = (state_q == BUSY) && (count_q == CW'(WIDTH - 1));

    // One iteration of each algorithm; both advance every BUSY cycle, op_q picks the result.
    assign prod_nxt  = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, divisor_q};
    // rem_shift < 2*divisor, so the difference fits in WIDTH+1 bits and its MSB is the sign.
    assign rem_ge    = ~rem_diff[WIDTH];
    assign rem_nxt   = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quo_nxt   = {quo_q[WIDTH-2:0], rem_ge};

    always_comb begin
        case (op_q)
            2'b00:   iter_result = prod_nxt[WIDTH-1:0];
            2'b01:   iter_result = prod_nxt[2*WIDTH-1:WIDTH];
            2'b10:   iter_result = quo_nxt;
            default: iter_result = rem_nxt;
        endcase
    end

    assign dz_result = bus.op_i[0] ? bus.data1_i : '1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    stall   = 1'b1;
                    state_d = div_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = !bus.flush_i;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q   <= '0;
            op_q      <= '0;
            prod_q    <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            result_q  <= '0;
        end else if (accept) begin
            count_q   <= '0;
            op_q      <= bus.op_i;
            prod_q    <= '0;
            mcand_q   <= {{WIDTH{1'b0}}, bus.data1_i};
            mplier_q  <= bus.data2_i;
            rem_q     <= '0;
            quo_q     <= bus.data1_i;
            divisor_q <= bus.data2_i;
            if (div_zero) begin
                result_q <= dz_result;
            end
        end else if ((state_q == BUSY) && !bus.flush_i) begin
            count_q  <= count_q + 1'b1;
            prod_q   <= prod_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            rem_q    <= rem_nxt;
            quo_q    <= quo_nxt;
            if (last_iter) begin
                result_q <= iter_result;
            end
        end
    end

    assign bus.stall_o   = stall;
    assign bus.done_o    = done;
    assign bus.result_o  = result_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized scoreboard bench for mul_div_unit: the driver pushes expected result and
// expected completion cycle; an independent monitor pops them on every done pulse.
module tb_mul_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_div_if #(.WIDTH(W)) bus ();

    mul_div_unit #(.WIDTH(W)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] last_exp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain unsigned arithmetic with RISC-V divide-by-zero results.
    function automatic logic [W-1:0] ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            2'd0:    return p[W-1:0];
            2'd1:    return p[2*W-1:W];
            2'd2:    return (b == 0) ? {W{1'b1}} : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        logic [W-1:0] e;
        int           l;
        forever begin
            @(negedge clk);
            #1;
            if (bus.done_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got done with result %h, expected no done", bus.result_o);
                end else begin
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    check("result", bus.result_o, e);
                    check("done_cycle", cyc, l);
                end
            end
        end
    end

    // Holds start_i high and scrambles operands until done, so only one op may run.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] e;
        int           lat, stall_cnt;
        bit           seen;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.data1_i = a;
        bus.data2_i = b;
        e   = ref_model(op, a, b);
        lat = (op[1] && b == 0) ? 1 : W + 1;
        exp_q.push_back(e);
        lat_q.push_back(cyc + lat);
        last_exp  = e;
        stall_cnt = 0;
        seen      = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            #1;
            if (bus.stall_o === 1'b1) stall_cnt++;
            if (bus.done_o === 1'b1) begin
                seen = 1;
            end else begin
                @(negedge clk);
                bus.op_i    = 2'($urandom_range(0, 3));
                bus.data1_i = $urandom;
                bus.data2_i = $urandom;
            end
        end
        bus.start_i = 1'b0;
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done in 100 cycles, expected done at +%0d", lat);
        end
        check("stall_cycles", W'(stall_cnt), W'(lat));
    endtask

    // Starts an op and kills it after n BUSY cycles with flush or reset.
    task automatic abort_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int n, input bit use_rst);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.data1_i = a;
        bus.data2_i = b;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (n - 1) @(negedge clk);
        if (use_rst) rst = 1'b1;
        else bus.flush_i = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        bus.flush_i = 1'b0;
        if (use_rst) last_exp = '0;
        #1;
        check(use_rst ? "rst_result" : "flush_result", bus.result_o, last_exp);
        check(use_rst ? "rst_done" : "flush_done", W'(bus.done_o), '0);
        check(use_rst ? "rst_stall" : "flush_stall", W'(bus.stall_o), '0);
        repeat (45) @(negedge clk);
    endtask

    initial begin
        logic [1:0]   op;
        logic [W-1:0] a, b;
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.op_i    = '0;
        bus.data1_i = '0;
        bus.data2_i = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_result", bus.result_o, '0);
        check("reset_done", W'(bus.done_o), '0);
        check("reset_stall", W'(bus.stall_o), '0);
        @(negedge clk);
        rst = 1'b0;

        // Flush in IDLE must block the start entirely.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.op_i    = 2'd0;
        bus.data1_i = 32'd3;
        bus.data2_i = 32'd3;
        #1;
        check("idle_flush_stall", W'(bus.stall_o), '0);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        repeat (40) @(negedge clk);

        run_op(2'd0, 32'd7, 32'd6);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'd2, 32'd100, 32'd7);
        run_op(2'd3, 32'd100, 32'd7);
        run_op(2'd2, 32'h8000_0000, 32'd1);
        run_op(2'd2, 32'd5, 32'd0);
        run_op(2'd3, 32'd5, 32'd0);

        abort_op(2'd0, 32'd123, 32'd456, 10, 1'b0);
        run_op(2'd2, 32'd9, 32'd3);
        abort_op(2'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5, 1'b1);
        run_op(2'd3, 32'hFFFF_FFFF, 32'd10);
        run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        repeat (40) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op(op, a, b);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", W'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
